// File: rtl/wb_arbiter_pkg.sv
// Shared completion-record types for the writeback path.
// The FU-facing interface and the writeback arbiter both use fu_complete_t.
package rv32i_types;

  localparam int unsigned NUM_FU   = 4;
  localparam int unsigned FU_IDX_W = $clog2(NUM_FU);

  typedef struct packed {
    logic [31:0] order;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
  } fu_complete_t;

endpackage

// File: rtl/wb_arbiter_port_fifo.sv
// Per-port completion FIFO: DEPTH entries, natural-wrap pointers, registered count.
// Push and pop in the same cycle keep the count and the order.
module wb_port_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rv32i_types::fu_complete_t  push_data,
  input  logic                       pop,
  output rv32i_types::fu_complete_t  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  import rv32i_types::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fu_complete_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers single-cycle FU completions per port and presents
// one per cycle to writeback, round-robin, holding the choice while stalled.
module wb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_FU-1:0]                      fu_valid,
  input  rv32i_types::fu_complete_t [NUM_FU-1:0] fu_data,
  output logic [NUM_FU-1:0]                      fu_ready,
  output logic                                   wb_valid,
  output rv32i_types::fu_complete_t              wb_data,
  output logic [$clog2(NUM_FU)-1:0]              wb_port,
  input  logic                                   wb_ready,
  output logic                                   overflow
);
  import rv32i_types::*;

  localparam int unsigned IDX_W = $clog2(NUM_FU);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                clr;
  logic [NUM_FU-1:0]   push;
  logic [NUM_FU-1:0]   pop;
  logic [NUM_FU-1:0]   full;
  logic [NUM_FU-1:0]   empty;
  logic [NUM_FU-1:0]   cand;
  fu_complete_t        heads  [NUM_FU];
  logic [CNT_W-1:0]    counts [NUM_FU];

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    rr_grant;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    grant_hold;
  logic                grant_lock;
  logic                handshake;

  assign clr = rst | flush;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_port
    assign fu_ready[i] = ~full[i];
    assign push[i]     = fu_valid[i] & ~full[i];
    assign cand[i]     = (counts[i] != '0);

    wb_port_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (clr),
      .push      (push[i]),
      .push_data (fu_data[i]),
      .pop       (pop[i]),
      .head      (heads[i]),
      .count     (counts[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  always_comb begin
    int unsigned pos;
    logic        found;
    rr_grant = '0;
    found    = 1'b0;
    pos      = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_FU;
      if (!found && cand[pos[IDX_W-1:0]]) begin
        rr_grant = pos[IDX_W-1:0];
        found    = 1'b1;
      end
    end
  end

  // A stalled presentation keeps its port so a later push cannot preempt it.
  assign grant     = grant_lock ? grant_hold : rr_grant;
  assign wb_valid  = ~(&empty);
  assign wb_port   = wb_valid ? grant : '0;
  assign wb_data   = wb_valid ? heads[grant] : '0;
  assign handshake = wb_valid & wb_ready;

  always_comb begin
    pop = '0;
    if (handshake) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rr_ptr     <= '0;
      grant_lock <= 1'b0;
      grant_hold <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= overflow | (|(fu_valid & ~fu_ready));
      if (handshake) begin
        rr_ptr     <= (grant == IDX_W'(NUM_FU - 1)) ? '0 : grant + 1'b1;
        grant_lock <= 1'b0;
      end else begin
        grant_lock <= wb_valid;
        grant_hold <= grant;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  import rv32i_types::*;

  localparam int NF    = 4;
  localparam int DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    rst, flush, wb_ready, wb_valid, overflow;
  logic [NF-1:0]           fu_valid, fu_ready;
  fu_complete_t [NF-1:0]   fu_data;
  fu_complete_t            wb_data;
  logic [1:0]              wb_port;

  wb_arbiter #(.NUM_FU(NF), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_data(fu_data),
    .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_data(wb_data), .wb_port(wb_port),
    .wb_ready(wb_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  fu_complete_t q [NF][$];
  int           rr, held;
  bit           ovf;
  int           n_checks, n_fails;
  int           order_cnt;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Port presented this cycle: the held one while stalled, else first non-empty from rr.
  function automatic int model_grant();
    if (held >= 0) return held;
    for (int k = 0; k < NF; k++)
      if (q[(rr + k) % NF].size() > 0) return (rr + k) % NF;
    return -1;
  endfunction

  function automatic fu_complete_t mk_rec(input int ord);
    fu_complete_t r;
    r.order   = 32'(ord);
    r.rd_addr = 5'($urandom);
    r.rd_data = $urandom;
    r.rd_we   = 1'($urandom);
    return r;
  endfunction

  task automatic model_update();
    int g;
    bit rdy [NF];
    if (rst || flush) begin
      for (int i = 0; i < NF; i++) q[i].delete();
      rr = 0; held = -1; ovf = 1'b0;
      return;
    end
    g = model_grant();
    for (int i = 0; i < NF; i++) rdy[i] = (q[i].size() != DEPTH);
    if (g >= 0 && wb_ready) begin
      void'(q[g].pop_front());
      rr   = (g + 1) % NF;
      held = -1;
    end else begin
      held = g;
    end
    for (int i = 0; i < NF; i++)
      if (fu_valid[i]) begin
        if (rdy[i]) q[i].push_back(fu_data[i]);
        else ovf = 1'b1;
      end
  endtask

  task automatic check_outputs();
    int g;
    logic [NF-1:0] exp_rdy;
    g = model_grant();
    check_val("wb_valid", wb_valid, g >= 0);
    if (g >= 0) begin
      check_val("wb_port", wb_port, g);
      check_val("wb_data", wb_data, q[g][0]);
    end else begin
      check_val("wb_data_idle", wb_data, 0);
    end
    for (int i = 0; i < NF; i++) exp_rdy[i] = (q[i].size() != DEPTH);
    check_val("fu_ready", fu_ready, exp_rdy);
    check_val("overflow", overflow, ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic [NF-1:0] v);
    fu_valid = v;
    for (int i = 0; i < NF; i++) begin
      fu_data[i] = mk_rec(order_cnt);
      order_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; drive('0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    fu_complete_t a, c;
    int prev;
    n_checks = 0; n_fails = 0; order_cnt = 100;
    rr = 0; held = -1; ovf = 1'b0;
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; fu_valid = '0; fu_data = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check_val("rst_valid", wb_valid, 1'b0);
    check_val("rst_ready", fu_ready, 4'hF);
    check_val("rst_ovf", overflow, 1'b0);
    check_val("rst_data", wb_data, 0);

    // Single push, one-cycle latency.
    wb_ready = 1'b1;
    drive(4'b0100); fu_data[2].order = 32'd5;
    tick();
    check_val("t1_valid", wb_valid, 1'b1);
    check_val("t1_port", wb_port, 2'd2);
    check_val("t1_order", wb_data.order, 32'd5);
    drive('0);
    tick();
    check_val("t1_drained", wb_valid, 1'b0);

    // Contention from rr=0 drains 0,1,3 and wraps rr back to 0.
    do_reset();
    wb_ready = 1'b1;
    drive(4'b1011);
    tick(); check_val("t2_p0", wb_port, 2'd0);
    drive('0);
    tick(); check_val("t2_p1", wb_port, 2'd1);
    tick(); check_val("t2_p3", wb_port, 2'd3);
    tick(); check_val("t2_empty", wb_valid, 1'b0);
    drive(4'b1001);
    tick(); check_val("t2_rr0", wb_port, 2'd0);
    drive('0); tick(); tick();

    // Fairness: ports 0 and 1 kept refilled.
    do_reset();
    wb_ready = 1'b1;
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      drive({2'b00, q[1].size() < DEPTH, q[0].size() < DEPTH});
      tick();
      if (n > 0) check_val("t3_alt", wb_port != 2'(prev), 1'b1);
      prev = int'(wb_port);
    end

    // Backpressure, overflow, and stability against a later push.
    do_reset();
    wb_ready = 1'b0;
    drive(4'b0010); a = fu_data[1];
    tick();
    drive(4'b0010); tick();
    check_val("t4_notready", fu_ready[1], 1'b0);
    drive(4'b0010); tick();
    check_val("t4_ovf", overflow, 1'b1);
    drive(4'b0001); tick();
    check_val("t4_hold_port", wb_port, 2'd1);
    check_val("t4_hold_data", wb_data, a);
    drive('0); tick();

    // Full port drains while a new record is pushed alongside the pop.
    do_reset();
    wb_ready = 1'b0;
    drive(4'b0010); tick();
    drive(4'b0010); tick();
    wb_ready = 1'b1; drive('0); tick();
    drive(4'b0010); c = fu_data[1]; tick();
    drive('0);
    check_val("t5_order", wb_data, c);
    check_val("t5_ovf", overflow, 1'b0);
    tick();

    // Flush mid-stall, with a pulse in the flush cycle that must be discarded.
    do_reset();
    wb_ready = 1'b0;
    drive(4'b0111); tick();
    drive(4'b0010); tick();
    drive(4'b0010); tick();
    flush = 1'b1; drive(4'b1000); tick();
    flush = 1'b0; drive('0);
    check_val("t6_valid", wb_valid, 1'b0);
    check_val("t6_ready", fu_ready, 4'hF);
    check_val("t6_ovf", overflow, 1'b0);
    wb_ready = 1'b1; drive(4'b1001); tick();
    check_val("t6_rr0", wb_port, 2'd0);

    // Random traffic including overflows, flushes and resets.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      wb_ready = ($urandom_range(0, 9) < 7);
      drive({($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)});
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
